booth2_seq_mult: RTL and testbench
==================================

// Module: booth2_seq_mult
// PURPOSE
//  Iterative signed radix-4 (Booth-2) multiplier controller and datapath.
//  - Accepts one operand pair over a valid/ready handshake.
//  - Retires one Booth-2 digit per clock into a shift-add accumulator.
//  - Returns the full-width product over a second valid/ready handshake.
//  - Serves as the low-area alternative to the Wallace/CSA array multiplier.
// PARAMETERS
//  WIDTH  16  operand width in bits; even and >= 4; product is 2*WIDTH bits
// PORTS
//  clk             in   1        rising-edge clock
//  rst_n           in   1        asynchronous active-low reset
//  in_valid        in   1        operand pair present
//  in_ready        out  1        block can accept operands this cycle
//  multiplicand    in   WIDTH    signed two's-complement A
//  multiplier      in   WIDTH    signed two's-complement B
//  out_valid       out  1        product valid; held until accepted
//  out_ready       in   1        downstream accepts product
//  product         out  2*WIDTH  signed A*B; stable while out_valid=1
//  busy            out  1        high in CALC
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n=0, then 1 from
//    the first cycle after release; out_valid=0, busy=0, product=0,
//    accumulator and counter cleared. Asserting reset mid-CALC or mid-DONE
//    aborts the operation and drops the result.
//  - FSM states:
//    - IDLE: in_ready=1. in_valid&in_ready -> latch A and B, append B[-1]=0,
//      acc=0, cnt=0 -> CALC.
//    - CALC: each cycle select digit {B[2i+1],B[2i],B[2i-1]}:
//      000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A.
//      Add the digit partial product, sign-extended to WIDTH+2 bits, into the
//      top of acc. Arithmetic-shift acc right 2; shift B right 2; cnt++.
//      After digit WIDTH/2-1 -> DONE.
//    - DONE: out_valid=1; product=acc.
//      - out_ready=1 with in_valid=0 -> IDLE.
//      - out_ready=1 with in_valid=1 -> accept new operands in the same cycle
//        and go straight to CALC. in_ready = out_ready in DONE.
//  - Latency: WIDTH/2 CALC cycles; with WIDTH=16, out_valid rises 9 cycles
//    after the accepting edge.
//  - Throughput: one product per WIDTH/2+1 cycles under back-to-back traffic.
//  - Width: negation of A uses WIDTH+2 bits, so A=-2^(WIDTH-1) with digit -2
//    cannot overflow. The product is exact for all inputs, including
//    (-2^(W-1))^2 = 2^(2W-2).
//  - Inputs are sampled only on the accepting edge; operand changes in CALC
//    are ignored. out_valid never drops without out_ready.
// CONFIGURATION
//  BOOTH2_EARLY_EXIT_EN
//  - Defined: in CALC, if every remaining multiplier bit plus the overlap bit
//    is all-0 or all-1, all remaining digits are zero. The block then
//    arithmetic-shifts acc by 2*(remaining digits) in one cycle and goes to
//    DONE, giving latency 1..WIDTH/2 cycles.
//  - Undefined: fixed WIDTH/2-cycle latency and no early-exit logic.
// STRUCTURE
//  - Package booth2_pkg holds:
//    - state enum {IDLE, CALC, DONE};
//    - digit enum {D_ZERO, D_P1, D_P2, D_M1, D_M2};
//    - function digit_of(logic [2:0]);
//    - localparam NDIGITS = WIDTH/2.
//  - One sub-module, booth2_pp_gen: combinational digit + A -> signed
//    WIDTH+2-bit partial product.
//  - FSM, counter, shift registers and accumulator stay in the top module.
// TESTING
//  1. W=16, A=3, B=5, out_ready=1 -> product=15; out_valid exactly 9 cycles
//     after accept (without EN).
//  2. A=-32768, B=-32768 -> product=32'h4000_0000. A=-1, B=7 -> product=-7.
//     A=0x7FFF, B=-32768 -> 32'hC000_8000.
//  3. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and product
//     held stable, in_ready=0. out_ready=1 -> IDLE the next cycle.
//  4. Back-to-back: in_valid held high with new operands while out_ready=1 in
//     DONE -> second accept on the same edge; products correct and in order.
//  5. Reset mid-CALC (cycle 3) -> out_valid=0 and busy=0 immediately;
//     in_ready=1 after release; the next operation computes correctly.
//  6. BOOTH2_EARLY_EXIT_EN, A=9, B=1 -> product=9 after 1 CALC cycle.
//     B=-1 -> product=-9 after 1 cycle. Random B -> matches the reference model.

Source files
------------

// File: rtl/booth2_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
// BOOTH2_EARLY_EXIT_EN (see booth2_seq_mult) does not change anything here.
package booth2_pkg;

    localparam int B2_WIDTH = 16;
    localparam int NDIGITS  = B2_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        D_ZERO = 3'd0,
        D_P1   = 3'd1,
        D_P2   = 3'd2,
        D_M1   = 3'd3,
        D_M2   = 3'd4
    } digit_e;

    // Recode an overlapping multiplier triple {b[2i+1], b[2i], b[2i-1]}.
    function automatic digit_e digit_of(input logic [2:0] bits);
        digit_e d;
        case (bits)
            3'b000, 3'b111: d = D_ZERO;
            3'b001, 3'b010: d = D_P1;
            3'b011:         d = D_P2;
            3'b100:         d = D_M2;
            3'b101, 3'b110: d = D_M1;
            default:        d = D_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth2_pp_gen.sv
// Booth-2 partial product generator: digit x A as a signed WIDTH+2-bit value.
// Two guard bits keep -2*(-2^(WIDTH-1)) representable.
module booth2_pp_gen
    import booth2_pkg::*;
#(
    parameter int WIDTH = B2_WIDTH
)(
    input  digit_e             i_digit,
    input  logic [WIDTH-1:0]   i_a,
    output logic [WIDTH+1:0]   o_pp
);

    logic [WIDTH+1:0] w_a_ext;
    logic [WIDTH+1:0] w_a_dbl;

    assign w_a_ext = {{2{i_a[WIDTH-1]}}, i_a};
    assign w_a_dbl = {w_a_ext[WIDTH:0], 1'b0};

    // Select the signed multiple of A for the current digit.
    always_comb begin
        o_pp = '0;
        case (i_digit)
            D_ZERO:  o_pp = '0;
            D_P1:    o_pp = w_a_ext;
            D_P2:    o_pp = w_a_dbl;
            D_M1:    o_pp = -w_a_ext;
            D_M2:    o_pp = -w_a_dbl;
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/booth2_seq_mult.sv
// Iterative signed radix-4 Booth multiplier, one digit per clock, valid/ready in and out.
// Optional BOOTH2_EARLY_EXIT_EN: finish as soon as all remaining digits are zero.
module booth2_seq_mult
    import booth2_pkg::*;
#(
    parameter int WIDTH = B2_WIDTH
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int N_DIG = (WIDTH == B2_WIDTH) ? NDIGITS : WIDTH / 2;
    localparam int ACC_W = 2 * WIDTH + 2;
    localparam int CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIG - 1);

    state_e               r_state;
    state_e               w_state_nx;
    logic                 r_rdy_en;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH:0]       r_b;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_step;
    logic                 w_last;
    logic                 w_early;
    digit_e               w_digit;
    logic [WIDTH+1:0]     w_pp;
    logic [WIDTH+1:0]     w_sum_hi;
    logic [ACC_W-1:0]     w_acc_pre;
    logic [ACC_W-1:0]     w_acc_nx;
    logic [WIDTH:0]       w_b_nx;

    booth2_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
        .i_digit (w_digit),
        .i_a     (r_a),
        .o_pp    (w_pp)
    );

    // r_b keeps the appended overlap bit at [0]; its low triple is the current digit.
    assign w_digit   = digit_of(r_b[2:0]);
    assign w_sum_hi  = r_acc[ACC_W-1:WIDTH] + w_pp;
    assign w_acc_pre = {w_sum_hi, r_acc[WIDTH-1:0]};
    assign w_b_nx    = $signed(r_b) >>> 2'd2;

`ifdef BOOTH2_EARLY_EXIT_EN
    logic [CNT_W:0]   w_rem;
    logic [CNT_W+1:0] w_shamt;

    // Once the shifted multiplier is all sign bits, every later digit is zero.
    assign w_rem    = {1'b0, LAST_CNT} - {1'b0, r_cnt} + (CNT_W + 1)'(1);
    assign w_shamt  = {w_rem, 1'b0};
    assign w_early  = (w_b_nx == '0) || (&w_b_nx);
    assign w_acc_nx = w_early ? ($signed(w_acc_pre) >>> w_shamt)
                              : ($signed(w_acc_pre) >>> 2'd2);
`else
    assign w_early  = 1'b0;
    assign w_acc_nx = $signed(w_acc_pre) >>> 2'd2;
`endif

    assign w_last     = (r_cnt == LAST_CNT) || w_early;
    assign w_in_ready = r_rdy_en && ((r_state == IDLE) ||
                                     ((r_state == DONE) && out_ready));

    // Next-state and handshake decode.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_step     = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && w_in_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = CALC;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nx = DONE;
                end else begin
                    w_state_nx = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid && w_in_ready) begin
                        w_accept   = 1'b1;
                        w_state_nx = CALC;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_state_nx = DONE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rdy_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_rdy_en    <= 1'b1;
            r_out_valid <= (w_state_nx == DONE);
            r_busy      <= (w_state_nx == CALC);
        end
    end

    // Operand capture, shift-add accumulation and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= multiplicand;
            r_b   <= {multiplier, 1'b0};
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_acc <= w_acc_nx;
            r_b   <= w_b_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_product <= w_acc_nx[2*WIDTH-1:0];
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;

endmodule

// File: tb/tb_booth2_seq_mult.sv
// Self-checking bench for booth2_seq_mult; expected products go through a scoreboard queue.
// Builds with or without BOOTH2_EARLY_EXIT_EN.
module tb_booth2_seq_mult;

    localparam int W = 16;
    localparam int N = W / 2;
`ifdef BOOTH2_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] product;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] sb [$];

    logic [W-1:0]   cor_a [5] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
    logic [W-1:0]   cor_b [5] = '{16'h8000, 16'h0007, 16'h8000, 16'h7FFF, 16'hFFFB};
    logic [2*W-1:0] cor_p [5] = '{32'h4000_0000, 32'hFFFF_FFF9, 32'hC000_8000,
                                  32'hC000_8000, 32'h0000_0000};

    always #5 clk = ~clk;

    booth2_seq_mult #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] ea;
        logic signed [2*W-1:0] eb;
        ea = {{W{a[W-1]}}, a};
        eb = {{W{b[W-1]}}, b};
        return ea * eb;
    endfunction

    // CALC cycles: N, or with early exit the first digit after which the
    // remaining multiplier bits (plus overlap) are all equal.
    function automatic int exp_calc(input logic [W-1:0] b, input bit early);
        logic signed [W:0] bx;
        logic signed [W:0] r;
        if (!early) return N;
        bx = {b, 1'b0};
        for (int c = 0; c < N; c++) begin
            r = bx >>> (2 * c + 2);
            if (r == 0 || r == -1) return c + 1;
        end
        return N;
    endfunction

    function automatic logic [2*W-1:0] pop_exp();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    // Present operands from a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        in_valid = 1'b1;
        multiplicand = a;
        multiplier = b;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) sb.push_back(ref_mul(a, b));
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_handshake in_ready=0 want=1");
        end
    endtask

    // Counts rising edges from the accepting edge (as 1) until out_valid; -1 on timeout.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (product !== 32'h0) begin bad++; $display("FAIL rst_product got=%h want=0", product); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        int n;
        logic [2*W-1:0] e;
        out_ready = 1'b1;
        accept(16'd3, 16'd5);
        wait_valid(n);
        total++; if (n != exp_calc(16'd5, EARLY) + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", n, exp_calc(16'd5, EARLY) + 1); end
        e = pop_exp();
        total++; if (product !== e) begin bad++; $display("FAIL basic_product got=%h want=%h", product, e); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_corners();
        int n;
        logic [2*W-1:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            accept(cor_a[i], cor_b[i]);
            wait_valid(n);
            e = pop_exp();
            total++; if (product !== cor_p[i]) begin bad++; $display("FAIL corner_%0d got=%h want=%h", i, product, cor_p[i]); end
            total++; if (n != exp_calc(cor_b[i], EARLY) + 1) begin bad++; $display("FAIL corner_lat_%0d got=%0d want=%0d", i, n, exp_calc(cor_b[i], EARLY) + 1); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [2*W-1:0] e;
        out_ready = 1'b0;
        accept(16'hFB2E, 16'd567);
        wait_valid(n);
        e = pop_exp();
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_%0d got=%b want=1", i, out_valid); end
            total++; if (product !== e) begin bad++; $display("FAIL bp_product_%0d got=%h want=%h", i, product, e); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_%0d got=%b want=0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_to_idle out_valid=%b busy=%b want 0/0", out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [2*W-1:0] e;
        logic [W-1:0] pa [4];
        logic [W-1:0] pb [4];
        for (int i = 0; i < 4; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        multiplicand = pa[0];
        multiplier = pb[0];
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%b want=1", in_ready); end
        sb.push_back(ref_mul(pa[0], pb[0]));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                multiplicand = pa[i + 1];
                multiplier = pb[i + 1];
            end
            wait_valid(n);
            total++; if (n != exp_calc(pb[i], EARLY) + 1) begin bad++; $display("FAIL b2b_period_%0d got=%0d want=%0d", i, n, exp_calc(pb[i], EARLY) + 1); end
            e = pop_exp();
            total++; if (product !== e) begin bad++; $display("FAIL b2b_product_%0d got=%h want=%h", i, product, e); end
            if (i < 3) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b want=1", i, in_ready); end
                sb.push_back(ref_mul(pa[i + 1], pb[i + 1]));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [2*W-1:0] e;
        out_ready = 1'b1;
        accept(16'd1234, 16'hAAAA);
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_abort out_valid=%b busy=%b want 0/0", out_valid, busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b want=1", in_ready); end
        accept(16'hFFB3, 16'd91);
        wait_valid(n);
        e = pop_exp();
        total++; if (product !== e) begin bad++; $display("FAIL mid_next_product got=%h want=%h", product, e); end
        @(negedge clk);
    endtask

    task automatic test_early_exit();
        int n;
        logic [2*W-1:0] e;
        int lat;
        lat = EARLY ? 2 : N + 1;
        out_ready = 1'b1;
        accept(16'd9, 16'd1);
        wait_valid(n);
        e = pop_exp();
        total++; if (n != lat) begin bad++; $display("FAIL ee_pos_latency got=%0d want=%0d", n, lat); end
        total++; if (product !== 32'd9) begin bad++; $display("FAIL ee_pos_product got=%h want=9", product); end
        @(negedge clk);
        accept(16'd9, 16'hFFFF);
        wait_valid(n);
        e = pop_exp();
        total++; if (n != lat) begin bad++; $display("FAIL ee_neg_latency got=%0d want=%0d", n, lat); end
        total++; if (product !== 32'hFFFF_FFF7) begin bad++; $display("FAIL ee_neg_product got=%h want=fffffff7", product); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        logic [2*W-1:0] e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom);
            if (i % 2 == 0) begin
                b = W'($urandom);
            end else begin
                b = W'($urandom_range(0, 63));
                if (i % 4 == 1) b = -b;
            end
            accept(a, b);
            wait_valid(n);
            e = pop_exp();
            total++; if (product !== e) begin bad++; $display("FAIL rand_product_%0d a=%h b=%h got=%h want=%h", i, a, b, product, e); end
            total++; if (n != exp_calc(b, EARLY) + 1) begin bad++; $display("FAIL rand_latency_%0d b=%h got=%0d want=%0d", i, b, n, exp_calc(b, EARLY) + 1); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_early_exit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
